// File: rtl/reg10_share_ctrl.sv
// reg10_share_ctrl: round-robin 4-phase load arbiter owning all writes to the shared holding register.
// Defining REG_SWEEP_EN adds the self-test sweep that walks q through a WIDTH+1 bit counter.
module reg10_share_ctrl #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] d0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d1,
  output logic             ack1,
  input  logic             sweep_go,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       q_src
);
`ifdef REG_SWEEP_EN
  typedef enum logic [1:0] {IDLE, ACK, SWEEP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACK} state_t;
`endif
  state_t state_q, state_d;
  logic rr_q, rr_d, gnt_q, gnt_d, ack0_q, ack0_d, ack1_q, ack1_d, pick;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0] src_q, src_d;
`ifdef REG_SWEEP_EN
  logic [WIDTH:0] ctr_q, ctr_d;
  logic busy_q, busy_d, done_q, done_d;
`endif
  // Round-robin pointer only matters when both requesters contend
  assign pick = (req0 & req1) ? rr_q : req1;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    ack0_d = ack0_q;
    ack1_d = ack1_q;
    q_d = q_q;
    src_d = src_q;
`ifdef REG_SWEEP_EN
    ctr_d = ctr_q;
    busy_d = busy_q;
    done_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef REG_SWEEP_EN
        if (sweep_go) begin
          state_d = SWEEP;
          ctr_d = '0;
          busy_d = 1'b1;
        end else
`endif
        if (req0 | req1) begin
          state_d = ACK;
          gnt_d = pick;
          q_d = pick ? d1 : d0;
          src_d = pick ? 2'b10 : 2'b01;
          ack0_d = !pick;
          ack1_d = pick;
        end
      end
      ACK: begin
        if (!(gnt_q ? req1 : req0)) begin
          state_d = IDLE;
          ack0_d = 1'b0;
          ack1_d = 1'b0;
          rr_d = !gnt_q;
        end
      end
`ifdef REG_SWEEP_EN
      SWEEP: begin
        q_d = ctr_q[WIDTH-1:0];
        src_d = 2'b11;
        ctr_d = ctr_q + {{WIDTH{1'b0}}, 1'b1};
        if (&ctr_q) begin
          state_d = IDLE;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      gnt_q <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      q_q <= '0;
      src_q <= 2'b00;
`ifdef REG_SWEEP_EN
      ctr_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      ack0_q <= ack0_d;
      ack1_q <= ack1_d;
      q_q <= q_d;
      src_q <= src_d;
`ifdef REG_SWEEP_EN
      ctr_q <= ctr_d;
      busy_q <= busy_d;
      done_q <= done_d;
`endif
    end
  end
  assign ack0 = ack0_q;
  assign ack1 = ack1_q;
  assign q = q_q;
  assign q_src = src_q;
`ifdef REG_SWEEP_EN
  assign sweep_busy = busy_q;
  assign sweep_done = done_q;
`else
  logic unused_sweep_go;
  assign unused_sweep_go = sweep_go;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
`endif
endmodule

// File: tb/tb_reg10_share_ctrl.sv
// tb_reg10_share_ctrl: directed checks of reset, handshake, round-robin contention and the sweep
// (sweep behaviour when REG_SWEEP_EN is defined, sweep inertness otherwise).
module tb_reg10_share_ctrl;
  localparam int W = 10;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0, sweep_go = 1'b0;
  logic [W-1:0] d0 = '0, d1 = '0;
  logic ack0, ack1, sweep_busy, sweep_done;
  logic [W-1:0] q;
  logic [1:0] q_src;
  int n_cmp = 0;
  int n_bad = 0;

  reg10_share_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .clr_n(clr_n),
    .req0(req0), .d0(d0), .ack0(ack0),
    .req1(req1), .d1(d1), .ack1(ack1),
    .sweep_go(sweep_go), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .q(q), .q_src(q_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_q", q, 0);
    chk("rst_src", q_src, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", sweep_busy, 0);
    chk("rst_done", sweep_done, 0);
    clr_n = 1'b1;
    // single load
    req0 = 1'b1;
    d0 = 10'h2A5;
    tick;
    chk("ld_q", q, 10'h2A5);
    chk("ld_src", q_src, 2'b01);
    chk("ld_ack0", ack0, 1);
    chk("ld_ack1", ack1, 0);
    req0 = 1'b0;
    tick;
    chk("ld_ack0_drop", ack0, 0);
    chk("ld_q_hold", q, 10'h2A5);
    // asynchronous reset mid-cycle while a handshake is open
    req0 = 1'b1;
    d0 = 10'h0F0;
    tick;
    chk("pre_rst_ack0", ack0, 1);
    #3;
    clr_n = 1'b0;
    #1;
    chk("arst_q", q, 0);
    chk("arst_src", q_src, 0);
    chk("arst_ack0", ack0, 0);
    req0 = 1'b0;
    tick;
    clr_n = 1'b1;
    // contention: rr starts at requester 0
    req0 = 1'b1;
    req1 = 1'b1;
    d0 = 10'h111;
    d1 = 10'h222;
    tick;
    chk("c1_q", q, 10'h111);
    chk("c1_src", q_src, 2'b01);
    chk("c1_ack0", ack0, 1);
    chk("c1_ack1", ack1, 0);
    tick;
    chk("c1_ack0_held", ack0, 1);
    d0 = 10'h3FF;
    req0 = 1'b0;
    tick;
    chk("c1_ack0_drop", ack0, 0);
    chk("c1_q_hold", q, 10'h111);
    req0 = 1'b1;
    tick;
    chk("c2_q", q, 10'h222);
    chk("c2_src", q_src, 2'b10);
    chk("c2_ack1", ack1, 1);
    chk("c2_ack0", ack0, 0);
    d1 = 10'h000;
    tick;
    chk("c2_d_change", q, 10'h222);
    req1 = 1'b0;
    tick;
    chk("c2_ack1_drop", ack1, 0);
    req1 = 1'b1;
    tick;
    chk("c3_q", q, 10'h3FF);
    chk("c3_ack0", ack0, 1);
    chk("c3_ack1", ack1, 0);
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    chk("c3_ack0_drop", ack0, 0);
    tick;
`ifndef REG_SWEEP_EN
    sweep_go = 1'b1;
    req0 = 1'b1;
    d0 = 10'h155;
    tick;
    chk("ns_busy", sweep_busy, 0);
    chk("ns_q", q, 10'h155);
    chk("ns_src", q_src, 2'b01);
    chk("ns_ack0", ack0, 1);
    tick;
    chk("ns_busy2", sweep_busy, 0);
    chk("ns_done", sweep_done, 0);
    chk("ns_q2", q, 10'h155);
    req0 = 1'b0;
    sweep_go = 1'b0;
    tick;
    chk("ns_ack0_drop", ack0, 0);
`else
    sweep_go = 1'b1;
    req1 = 1'b1;
    d1 = 10'h0AB;
    tick;
    chk("sw_busy", sweep_busy, 1);
    chk("sw_q_unch", q, 10'h3FF);
    chk("sw_ack1", ack1, 0);
    sweep_go = 1'b0;
    for (int k = 0; k < 2048; k++) begin
      tick;
      chk("sw_q", q, k % 1024);
      chk("sw_busy", sweep_busy, (k != 2047) ? 1 : 0);
      chk("sw_done", sweep_done, (k == 2047) ? 1 : 0);
      chk("sw_ack1", ack1, 0);
    end
    chk("sw_src", q_src, 2'b11);
    tick;
    chk("sw_done_clr", sweep_done, 0);
    chk("sw_post_ack1", ack1, 1);
    chk("sw_post_q", q, 10'h0AB);
    chk("sw_post_src", q_src, 2'b10);
    req1 = 1'b0;
    tick;
    chk("sw_post_drop", ack1, 0);
    tick;
    // reset during a sweep
    sweep_go = 1'b1;
    tick;
    sweep_go = 1'b0;
    repeat (500) tick;
    chk("mr_busy", sweep_busy, 1);
    chk("mr_q", q, 10'd499);
    #3;
    clr_n = 1'b0;
    #1;
    chk("mr_q0", q, 0);
    chk("mr_busy0", sweep_busy, 0);
    chk("mr_src0", q_src, 0);
    tick;
    clr_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("mr_no_done", sweep_done, 0);
      chk("mr_idle_busy", sweep_busy, 0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
